// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIBBLE_W = 4;

    function automatic int cnt_width(input int nibbles);
        return $clog2(nibbles + 1);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequenced LSB-nibble-first through one external 4-bit adder.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                      in_cin,
    input  logic                      in_sub,
    output logic [NIBBLE_W-1:0]       add_a,
    output logic [NIBBLE_W-1:0]       add_b,
    output logic                      add_ci,
    input  logic [NIBBLE_W-1:0]       add_sum,
    input  logic                      add_co,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                      out_co,
    output logic                      out_ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            a_msb, b_msb;
    logic            accept, last;
    logic [W+3:0]    sum_cat;
    logic [W-1:0]    sum_next;

    assign accept   = in_valid && in_ready;
    assign last     = (state == RUN) && (cnt == LAST);
    // Concatenate then drop the low nibble so NIBBLES=1 needs no special case.
    assign sum_cat  = {add_sum, sum_q};
    assign sum_next = sum_cat[W+3:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        add_a    = '0;
        add_b    = '0;
        add_ci   = 1'b0;
        if (state == RUN) begin
            add_a  = a_q[NIBBLE_W-1:0];
            add_b  = b_q[NIBBLE_W-1:0];
            add_ci = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= in_sub ? 1'b1 : in_cin;
            a_q   <= in_a;
            b_q   <= in_sub ? ~in_b : in_b;
            sum_q <= '0;
            a_msb <= in_a[W-1];
            b_msb <= in_sub ? ~in_b[W-1] : in_b[W-1];
        end else if (state == RUN) begin
            cnt   <= cnt + 1'b1;
            carry <= add_co;
            a_q   <= a_q >> NIBBLE_W;
            b_q   <= b_q >> NIBBLE_W;
            sum_q <= sum_next;
        end
    end

    // Result registers load on the final capture and hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (last) begin
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_co    <= add_co;
            out_ovf   <= (a_msb == b_msb) && (add_sum[NIBBLE_W-1] != a_msb);
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench: 16-bit and 4-bit instances, each with a behavioural 4-bit adder.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vec = 0;
    int miscmp = 0;

    // 16-bit instance
    logic        in_valid = 0, in_cin = 0, in_sub = 0, out_ready = 0;
    logic [15:0] in_a = '0, in_b = '0;
    logic        in_ready, add_ci, add_co, out_valid, out_co, out_ovf;
    logic [3:0]  add_a, add_b, add_sum;
    logic [15:0] out_sum;

    assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

    nibble_serial_adder_ctrl #(.NIBBLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sum(add_sum), .add_co(add_co),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_co(out_co), .out_ovf(out_ovf)
    );

    // 4-bit instance
    logic       v1_in_valid = 0, v1_in_cin = 0, v1_in_sub = 0, v1_out_ready = 0;
    logic [3:0] v1_in_a = '0, v1_in_b = '0;
    logic       v1_in_ready, v1_add_ci, v1_add_co, v1_out_valid, v1_out_co, v1_out_ovf;
    logic [3:0] v1_add_a, v1_add_b, v1_add_sum, v1_out_sum;

    assign {v1_add_co, v1_add_sum} = {1'b0, v1_add_a} + {1'b0, v1_add_b} + {4'b0, v1_add_ci};

    nibble_serial_adder_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_a(v1_in_a), .in_b(v1_in_b),
        .in_cin(v1_in_cin), .in_sub(v1_in_sub),
        .add_a(v1_add_a), .add_b(v1_add_b), .add_ci(v1_add_ci), .add_sum(v1_add_sum),
        .add_co(v1_add_co),
        .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_sum(v1_out_sum),
        .out_co(v1_out_co), .out_ovf(v1_out_ovf)
    );

    // Issue one operation on the 16-bit instance; returns per-cycle add_ci/add_b
    // and the number of edges from accept to out_valid (-1 on timeout).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, output logic [3:0] ci_seq,
                          output logic [15:0] b_seq, output int lat);
        ci_seq = '0;
        b_seq  = '0;
        lat    = -1;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            if (out_valid) begin
                lat = i;
                break;
            end
            if (i < 4) begin
                ci_seq[i]       = add_ci;
                b_seq[i*4 +: 4] = add_b;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0 ||
            out_co !== 1'b0 || out_ovf !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_outputs: rdy=%b vld=%b sum=%h co=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, out_sum, out_co, out_ovf);
        end
        vec++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_ci !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_adder_drive: a=%h b=%h ci=%b, want 0 0 0", add_a, add_b, add_ci);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_basic();
        logic [3:0]  ci;
        logic [15:0] bs;
        int          lat;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, ci, bs, lat);
        vec++;
        if (lat !== 4) begin
            miscmp++;
            $display("FAIL basic_latency: got %0d edges, want 4", lat);
        end
        vec++;
        if (out_sum !== 16'h5555 || out_co !== 1'b0 || out_ovf !== 1'b0) begin
            miscmp++;
            $display("FAIL basic_result: sum=%h co=%b ovf=%b, want 5555 0 0", out_sum, out_co, out_ovf);
        end
        vec++;
        if (ci !== 4'b0000) begin
            miscmp++;
            $display("FAIL basic_ci_seq: got %b, want 0000", ci);
        end
        consume();
    endtask

    task automatic test_carry_chain();
        logic [3:0]  ci;
        logic [15:0] bs;
        int          lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, ci, bs, lat);
        vec++;
        if (lat !== 4 || out_sum !== 16'h0000 || out_co !== 1'b1 || out_ovf !== 1'b0) begin
            miscmp++;
            $display("FAIL carry_result: lat=%0d sum=%h co=%b ovf=%b, want 4 0000 1 0",
                     lat, out_sum, out_co, out_ovf);
        end
        // ci_seq bit k is cycle k: 0,1,1,1 -> 4'b1110; add_b nibbles 1,0,0,0
        vec++;
        if (ci !== 4'b1110) begin
            miscmp++;
            $display("FAIL carry_ci_seq: got %b, want 1110", ci);
        end
        vec++;
        if (bs !== 16'h0001) begin
            miscmp++;
            $display("FAIL carry_b_seq: got %h, want 0001", bs);
        end
        consume();
    endtask

    task automatic test_signed();
        logic [3:0]  ci;
        logic [15:0] bs;
        int          lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, ci, bs, lat);
        vec++;
        if (out_sum !== 16'h8000 || out_co !== 1'b0 || out_ovf !== 1'b1) begin
            miscmp++;
            $display("FAIL signed_add_ovf: sum=%h co=%b ovf=%b, want 8000 0 1", out_sum, out_co, out_ovf);
        end
        consume();
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, ci, bs, lat);
        vec++;
        if (out_sum !== 16'h7FFF || out_co !== 1'b1 || out_ovf !== 1'b1) begin
            miscmp++;
            $display("FAIL signed_sub_ovf: sum=%h co=%b ovf=%b, want 7fff 1 1", out_sum, out_co, out_ovf);
        end
        vec++;
        if (bs !== 16'hFFFE) begin
            miscmp++;
            $display("FAIL sub_inverted_b: got %h, want fffe", bs);
        end
        consume();
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, ci, bs, lat);
        vec++;
        if (out_sum !== 16'hFFFE || out_co !== 1'b0 || out_ovf !== 1'b0) begin
            miscmp++;
            $display("FAIL signed_sub_borrow: sum=%h co=%b ovf=%b, want fffe 0 0", out_sum, out_co, out_ovf);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ci;
        logic [15:0] bs;
        int          lat;
        int          bad;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, ci, bs, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_a = 16'hAAAA; in_b = 16'h1111; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sum !== 16'h5555 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        vec++;
        if (bad != 0) begin
            miscmp++;
            $display("FAIL backpressure_hold: %0d bad cycles, vld=%b sum=%h rdy=%b, want 1 5555 0",
                     bad, out_valid, out_sum, in_ready);
        end
        consume();
        vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscmp++;
            $display("FAIL release_ready: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        run_op(16'h1111, 16'h2222, 1'b1, 1'b0, ci, bs, lat);
        vec++;
        if (lat !== 4 || out_sum !== 16'h3334 || out_co !== 1'b0 || out_ovf !== 1'b0) begin
            miscmp++;
            $display("FAIL back_to_back: lat=%0d sum=%h co=%b ovf=%b, want 4 3334 0 0",
                     lat, out_sum, out_co, out_ovf);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        logic [3:0]  ci;
        logic [15:0] bs;
        int          lat;
        @(negedge clk);
        in_a = 16'hABCD; in_b = 16'h1234; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        vec++;
        if (add_a !== 4'hB || add_b !== 4'h2) begin
            miscmp++;
            $display("FAIL mid_run_drive: a=%h b=%h, want b 2", add_a, add_b);
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if (out_valid !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0 || add_ci !== 1'b0 ||
            in_ready !== 1'b1) begin
            miscmp++;
            $display("FAIL async_abort: vld=%b a=%h b=%h ci=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, add_a, add_b, add_ci, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, ci, bs, lat);
        vec++;
        if (lat !== 4 || out_sum !== 16'h0100 || out_co !== 1'b0) begin
            miscmp++;
            $display("FAIL after_abort: lat=%0d sum=%h co=%b, want 4 0100 0", lat, out_sum, out_co);
        end
        consume();
    endtask

    task automatic test_nibbles1();
        int lat;
        lat = -1;
        @(negedge clk);
        v1_in_a = 4'h9; v1_in_b = 4'h8; v1_in_cin = 1'b0; v1_in_sub = 1'b0; v1_in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) v1_in_valid = 1'b0;
            if (v1_out_valid) begin
                lat = i;
                break;
            end
        end
        vec++;
        if (lat !== 1) begin
            miscmp++;
            $display("FAIL n1_latency: got %0d edges, want 1", lat);
        end
        vec++;
        if (v1_out_sum !== 4'h1 || v1_out_co !== 1'b1 || v1_out_ovf !== 1'b1) begin
            miscmp++;
            $display("FAIL n1_result: sum=%h co=%b ovf=%b, want 1 1 1", v1_out_sum, v1_out_co, v1_out_ovf);
        end
        v1_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1_out_ready = 1'b0;
        vec++;
        if (v1_out_valid !== 1'b0 || v1_in_ready !== 1'b1) begin
            miscmp++;
            $display("FAIL n1_release: vld=%b rdy=%b, want 0 1", v1_out_valid, v1_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_chain();
        test_signed();
        test_back_to_back();
        test_reset_mid_run();
        test_nibbles1();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
